// File: rtl/op_lut_pkt_sequencer_if.sv
// Packet-buffer, header-parser and downstream signals of the op_lut sequencer.
// master = sequencer side, slave = surrounding pipeline side.
interface op_lut_pkt_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8
);
    logic [DATA_WIDTH-1:0] buf_data;
    logic [CTRL_WIDTH-1:0] buf_ctrl;
    logic                  buf_empty;
    logic                  buf_rd_en;
    logic                  is_from_cpu;
    logic [NUM_QUEUES-1:0] to_cpu_output_port;
    logic [NUM_QUEUES-1:0] from_cpu_output_port;
    logic                  is_from_cpu_vld;
    logic                  rd_hdr_parser;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (
        input  buf_data, buf_ctrl, buf_empty,
        output buf_rd_en,
        input  is_from_cpu, to_cpu_output_port,
        input  from_cpu_output_port, is_from_cpu_vld,
        output rd_hdr_parser,
        output out_data, out_ctrl, out_wr,
        input  out_rdy
    );

    modport slave (
        output buf_data, buf_ctrl, buf_empty,
        input  buf_rd_en,
        output is_from_cpu, to_cpu_output_port,
        output from_cpu_output_port, is_from_cpu_vld,
        input  rd_hdr_parser,
        input  out_data, out_ctrl, out_wr,
        output out_rdy
    );
endinterface

// File: rtl/op_lut_pkt_sequencer.sv
// Pairs buffered packets with parser results, stamps the IOQ dst-port field.
// Optional per-direction packet counters: define OP_LUT_SEQ_STATS_EN.
module op_lut_pkt_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8,
    parameter logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF,
    parameter int DST_PORT_POS = 0
) (
    input logic clk,
    input logic reset,
    op_lut_pkt_sequencer_if.master bus
`ifdef OP_LUT_SEQ_STATS_EN
    ,
    output logic [31:0] pkts_from_cpu,
    output logic [31:0] pkts_to_cpu
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        HDRS,
        PAYLOAD
    } state_t;

    state_t state;
    logic [15:0] dst_port;
    logic [15:0] sel_port;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic xfer;
    logic is_ioq;
    logic eop;
`ifdef OP_LUT_SEQ_STATS_EN
    logic from_flag;
`endif

    // Word moves only while sequencing a packet, buffer has data, sink ready
    assign xfer = (state != IDLE) && !bus.buf_empty && bus.out_rdy;
    assign is_ioq = (bus.buf_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign eop = xfer && (state == PAYLOAD) && (bus.buf_ctrl != '0);
    assign bus.buf_rd_en = xfer;
    assign bus.rd_hdr_parser = eop;

    // Pick the destination port for the packet about to start
    always_comb begin
        sel_port = '0;
        if (bus.is_from_cpu) begin
            sel_port = 16'(bus.from_cpu_output_port);
        end else begin
            sel_port = 16'(bus.to_cpu_output_port);
        end
    end

    // Overwrite the dst-port field of every IOQ header word
    always_comb begin
        fwd_data = bus.buf_data;
        if (state == HDRS && is_ioq) begin
            fwd_data[DST_PORT_POS +: 16] = dst_port;
        end
    end

    // Packet FSM with registered output word and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dst_port     <= '0;
            bus.out_data <= '0;
            bus.out_ctrl <= '0;
            bus.out_wr   <= 1'b0;
`ifdef OP_LUT_SEQ_STATS_EN
            from_flag     <= 1'b0;
            pkts_from_cpu <= '0;
            pkts_to_cpu   <= '0;
`endif
        end else begin
            bus.out_wr <= xfer;
            if (xfer) begin
                bus.out_data <= fwd_data;
                bus.out_ctrl <= bus.buf_ctrl;
            end
            unique case (state)
                IDLE: begin
                    if (bus.is_from_cpu_vld && !bus.buf_empty) begin
                        dst_port <= sel_port;
`ifdef OP_LUT_SEQ_STATS_EN
                        from_flag <= bus.is_from_cpu;
`endif
                        state <= HDRS;
                    end
                end
                HDRS: begin
                    if (xfer && bus.buf_ctrl == '0) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (eop) begin
`ifdef OP_LUT_SEQ_STATS_EN
                        if (from_flag) begin
                            pkts_from_cpu <= pkts_from_cpu + 32'd1;
                        end else begin
                            pkts_to_cpu <= pkts_to_cpu + 32'd1;
                        end
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_lut_pkt_sequencer.sv
// Directed bench for op_lut_pkt_sequencer with buffer/parser queue models.
// Counter checks are compiled in only with OP_LUT_SEQ_STATS_EN.
module tb_op_lut_pkt_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    op_lut_pkt_sequencer_if bus ();

`ifdef OP_LUT_SEQ_STATS_EN
    logic [31:0] pkts_from_cpu;
    logic [31:0] pkts_to_cpu;
`endif

    op_lut_pkt_sequencer dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef OP_LUT_SEQ_STATS_EN
        ,
        .pkts_from_cpu(pkts_from_cpu),
        .pkts_to_cpu(pkts_to_cpu)
`endif
    );

    logic [71:0] bq[$];
    logic [16:0] pq[$];
    logic [71:0] rx[$];
    logic [71:0] exp_q[$];
    int hdr_cyc[$];
    int eop_cyc[$];
    int cyc_n = 0;
    int rdh_cnt = 0;
    int errors = 0;
    int checks = 0;
    int c0;
    bit in_pkt = 0;
    bit rdy = 1;
    bit stall_rd = 0;
    bit stall_wr = 0;

    task automatic chk(string tag, logic [71:0] got, logic [71:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive();
        bus.buf_empty = (bq.size() == 0);
        bus.buf_data = bus.buf_empty ? 64'h0 : bq[0][63:0];
        bus.buf_ctrl = bus.buf_empty ? 8'h0 : bq[0][71:64];
        bus.is_from_cpu_vld = (pq.size() != 0);
        bus.is_from_cpu = (pq.size() != 0) ? pq[0][16] : 1'b0;
        bus.to_cpu_output_port = (pq.size() != 0) ? pq[0][15:8] : 8'h0;
        bus.from_cpu_output_port = (pq.size() != 0) ? pq[0][7:0] : 8'h0;
        bus.out_rdy = rdy;
    endtask

    task automatic cyc();
        logic rd;
        logic rh;
        cyc_n++;
        drive();
        #1;
        rd = bus.buf_rd_en;
        rh = bus.rd_hdr_parser;
        if (!rdy && rd) stall_rd = 1;
        @(posedge clk);
        if (rd) begin
            if (!in_pkt) hdr_cyc.push_back(cyc_n);
            in_pkt = 1;
            void'(bq.pop_front());
        end
        if (rh) begin
            eop_cyc.push_back(cyc_n);
            in_pkt = 0;
            rdh_cnt++;
            void'(pq.pop_front());
        end
        #1;
        if (bus.out_wr) rx.push_back({bus.out_ctrl, bus.out_data});
        if (!rdy && bus.out_wr) stall_wr = 1;
        @(negedge clk);
    endtask

    task automatic run_until(string tag, int n, int budget);
        for (int k = 0; k < budget && rx.size() < n; k++) cyc();
        chk({tag, "_timeout"}, 72'(rx.size() >= n), 72'(1));
    endtask

    task automatic check_pkt(string tag);
        repeat (3) cyc();
        chk({tag, "_len"}, 72'(rx.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx.size()) begin
                chk($sformatf("%s_w%0d", tag, i), rx[i], exp_q[i]);
            end
        end
        rx.delete();
    endtask

    initial begin
        reset = 1'b1;
        bq = '{{8'hFF, 64'h0000_0002_0003_0000},
               {8'h00, 64'h1111_1111_1111_1111},
               {8'h00, 64'h2222_2222_2222_2222},
               {8'h04, 64'h3333_3333_3333_3333}};
        pq = '{{1'b0, 8'h08, 8'h00}};
        drive();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_wr", 72'(bus.out_wr), 72'(0));
        chk("rst_out_data", 72'(bus.out_data), 72'(0));
        chk("rst_out_ctrl", 72'(bus.out_ctrl), 72'(0));
        chk("rst_rd_en", 72'(bus.buf_rd_en), 72'(0));
        chk("rst_rdh", 72'(bus.rd_hdr_parser), 72'(0));
`ifdef OP_LUT_SEQ_STATS_EN
        chk("rst_from", 72'(pkts_from_cpu), 72'(0));
        chk("rst_to", 72'(pkts_to_cpu), 72'(0));
`endif
        @(negedge clk);
        reset = 1'b0;

        // Packet A from MAC port 2
        run_until("A", 4, 30);
        exp_q = '{{8'hFF, 64'h0000_0002_0003_0008},
                  {8'h00, 64'h1111_1111_1111_1111},
                  {8'h00, 64'h2222_2222_2222_2222},
                  {8'h04, 64'h3333_3333_3333_3333}};
        check_pkt("A");
        chk("A_rdh", 72'(rdh_cnt), 72'(1));
`ifdef OP_LUT_SEQ_STATS_EN
        chk("A_to", 72'(pkts_to_cpu), 72'(1));
        chk("A_from", 72'(pkts_from_cpu), 72'(0));
`endif

        // Packet from CPU port 3, stalled 5 cycles mid-payload
        bq = '{{8'hFF, 64'h0000_0003_0001_0000},
               {8'h00, 64'hD1D1_D1D1_D1D1_D1D1},
               {8'h00, 64'hD2D2_D2D2_D2D2_D2D2},
               {8'h00, 64'hD3D3_D3D3_D3D3_D3D3},
               {8'h00, 64'hD4D4_D4D4_D4D4_D4D4},
               {8'h80, 64'hE0E0_E0E0_E0E0_E0E0}};
        pq = '{{1'b1, 8'h08, 8'h04}};
        run_until("P_pre", 3, 30);
        rdy = 0;
        repeat (5) cyc();
        chk("stall_rd_en", 72'(stall_rd), 72'(0));
        chk("stall_out_wr", 72'(stall_wr), 72'(0));
        chk("stall_len", 72'(rx.size()), 72'(3));
        rdy = 1;
        run_until("P", 6, 30);
        exp_q = '{{8'hFF, 64'h0000_0003_0001_0004},
                  {8'h00, 64'hD1D1_D1D1_D1D1_D1D1},
                  {8'h00, 64'hD2D2_D2D2_D2D2_D2D2},
                  {8'h00, 64'hD3D3_D3D3_D3D3_D3D3},
                  {8'h00, 64'hD4D4_D4D4_D4D4_D4D4},
                  {8'h80, 64'hE0E0_E0E0_E0E0_E0E0}};
        check_pkt("P");
        chk("P_rdh", 72'(rdh_cnt), 72'(2));
`ifdef OP_LUT_SEQ_STATS_EN
        chk("P_from", 72'(pkts_from_cpu), 72'(1));
`endif

        // Back-to-back B then C; C has two IOQ words
        hdr_cyc.delete();
        eop_cyc.delete();
        bq = '{{8'hFF, 64'h1234_5678_9ABC_FFFF},
               {8'h00, 64'h0000_0000_0000_00B0},
               {8'h10, 64'h0000_0000_0000_00B1},
               {8'hFF, 64'hFFFF_FFFF_FFFF_0000},
               {8'hFF, 64'h0000_0000_0000_0000},
               {8'h00, 64'h0000_0000_0000_00C0},
               {8'h02, 64'h0000_0000_0000_00C1}};
        pq = '{{1'b1, 8'h40, 8'h10}, {1'b0, 8'h20, 8'h01}};
        run_until("BC", 7, 40);
        exp_q = '{{8'hFF, 64'h1234_5678_9ABC_0010},
                  {8'h00, 64'h0000_0000_0000_00B0},
                  {8'h10, 64'h0000_0000_0000_00B1},
                  {8'hFF, 64'hFFFF_FFFF_FFFF_0020},
                  {8'hFF, 64'h0000_0000_0000_0020},
                  {8'h00, 64'h0000_0000_0000_00C0},
                  {8'h02, 64'h0000_0000_0000_00C1}};
        check_pkt("BC");
        chk("BC_npkts", 72'(hdr_cyc.size()), 72'(2));
        if (hdr_cyc.size() == 2 && eop_cyc.size() >= 1) begin
            chk("BC_gap", 72'(hdr_cyc[1] - eop_cyc[0]), 72'(2));
        end
        chk("BC_rdh", 72'(rdh_cnt), 72'(4));
`ifdef OP_LUT_SEQ_STATS_EN
        chk("BC_from", 72'(pkts_from_cpu), 72'(2));
        chk("BC_to", 72'(pkts_to_cpu), 72'(2));
`endif

        // Packet D waits 10 cycles for its parser result
        hdr_cyc.delete();
        bq = '{{8'hFF, 64'h5555_5555_5555_5555},
               {8'h00, 64'h0000_0000_0000_00D0},
               {8'h01, 64'h0000_0000_0000_00D1}};
        repeat (10) cyc();
        chk("D_wait_out", 72'(rx.size()), 72'(0));
        chk("D_wait_pop", 72'(hdr_cyc.size()), 72'(0));
        pq = '{{1'b0, 8'h02, 8'h80}};
        c0 = cyc_n + 1;
        run_until("D", 3, 20);
        if (hdr_cyc.size() != 0) begin
            chk("D_start", 72'(hdr_cyc[0]), 72'(c0 + 1));
        end
        exp_q = '{{8'hFF, 64'h5555_5555_5555_0002},
                  {8'h00, 64'h0000_0000_0000_00D0},
                  {8'h01, 64'h0000_0000_0000_00D1}};
        check_pkt("D");
`ifdef OP_LUT_SEQ_STATS_EN
        chk("D_to", 72'(pkts_to_cpu), 72'(3));
`endif

        // Reset in the middle of packet E's payload
        bq = '{{8'hFF, 64'h0},
               {8'h00, 64'h0000_0000_0000_00E0},
               {8'h00, 64'h0000_0000_0000_00E1},
               {8'h00, 64'h0000_0000_0000_00E2},
               {8'h01, 64'h0000_0000_0000_00E3}};
        pq = '{{1'b1, 8'h01, 8'h02}};
        run_until("E", 3, 20);
        chk("E_pre_wr", 72'(bus.out_wr), 72'(1));
        reset = 1'b1;
        #1;
        chk("E_rst_wr", 72'(bus.out_wr), 72'(0));
        chk("E_rst_rd", 72'(bus.buf_rd_en), 72'(0));
        chk("E_rst_rdh", 72'(bus.rd_hdr_parser), 72'(0));
        chk("E_rst_data", 72'(bus.out_data), 72'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bq.delete();
        pq.delete();
        rx.delete();
        in_pkt = 0;
`ifdef OP_LUT_SEQ_STATS_EN
        chk("E_cnt_from", 72'(pkts_from_cpu), 72'(0));
        chk("E_cnt_to", 72'(pkts_to_cpu), 72'(0));
`endif

        // Fresh packet F after reset
        bq = '{{8'hFF, 64'h0},
               {8'h00, 64'h0000_0000_0000_00F0},
               {8'h08, 64'h0000_0000_0000_00F1}};
        pq = '{{1'b1, 8'h01, 8'h02}};
        run_until("F", 3, 20);
        exp_q = '{{8'hFF, 64'h0000_0000_0000_0002},
                  {8'h00, 64'h0000_0000_0000_00F0},
                  {8'h08, 64'h0000_0000_0000_00F1}};
        check_pkt("F");
        chk("F_pq_empty", 72'(pq.size()), 72'(0));
`ifdef OP_LUT_SEQ_STATS_EN
        chk("F_from", 72'(pkts_from_cpu), 72'(1));
        chk("F_to", 72'(pkts_to_cpu), 72'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_lut_pkt_sequencer.md
# op_lut_pkt_sequencer

Sequences packets through the output-port-lookup stage by pairing each buffered packet with its header-parser result (source CPU/MAC classification and candidate output ports). It writes the selected destination port into the IOQ module header word and forwards the packet downstream with ready/write flow control. It pops one parser entry per packet on the packet's last word. It sits between the op_lut header parser / packet buffer FIFO and the next pipeline stage.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath width
- CTRL_WIDTH, DATA_WIDTH/8, control width
- NUM_QUEUES, 8, number of ports (even = MAC, odd = CPU)
- IO_QUEUE_STAGE_NUM, 8'hFF, ctrl value marking the IOQ module header word
- DST_PORT_POS, 0, LSB of the 16-bit one-hot destination-port field in the IOQ word

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- buf_data  in  DATA_WIDTH  head word of the fallthrough packet buffer
- buf_ctrl  in  CTRL_WIDTH  ctrl of the head word
- buf_empty  in  1  packet buffer empty
- buf_rd_en  out  1  pop packet buffer
- is_from_cpu  in  1  parser result: packet came from a CPU port
- to_cpu_output_port  in  NUM_QUEUES  one-hot CPU port for the packet's source
- from_cpu_output_port  in  NUM_QUEUES  one-hot MAC port for the packet's source
- is_from_cpu_vld  in  1  parser result available
- rd_hdr_parser  out  1  pop parser result
- out_data  out  DATA_WIDTH  forwarded word
- out_ctrl  out  CTRL_WIDTH  forwarded ctrl
- out_wr  out  1  forwarded word valid
- out_rdy  in  1  downstream can accept a word
- pkts_from_cpu  out  32  (OP_LUT_SEQ_STATS_EN only) count of packets sent with is_from_cpu=1
- pkts_to_cpu  out  32  (OP_LUT_SEQ_STATS_EN only) count of packets sent with is_from_cpu=0

## Operation
- FSM states: IDLE, HDRS, PAYLOAD.
- IDLE: when is_from_cpu_vld && !buf_empty:
  - latch dst_port = is_from_cpu ? from_cpu_output_port : to_cpu_output_port, zero-extended to 16 bits;
  - latch from_flag = is_from_cpu;
  - go to HDRS.
  - No word moves in IDLE.
- Transfer condition (HDRS/PAYLOAD): xfer = !buf_empty && out_rdy. buf_rd_en = xfer (combinational).
- HDRS: each transferred word is forwarded.
  - If buf_ctrl == IO_QUEUE_STAGE_NUM, bits [DST_PORT_POS +: 16] are replaced by dst_port; all other bits pass unchanged.
  - A transferred word with buf_ctrl == 0 moves the FSM to PAYLOAD.
- PAYLOAD: words are forwarded unchanged.
  - A transferred word with buf_ctrl != 0 is EOP. In that cycle rd_hdr_parser = 1, the stats counter selected by from_flag increments, and the FSM goes to IDLE.
- rd_hdr_parser is high only in an EOP transfer cycle, exactly once per packet.
- Multiple IOQ words in one header: every one is rewritten.
- Parser valid while the buffer is empty, or buffer non-empty while the parser is not valid: stay in IDLE, no outputs.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state = IDLE;
  - out_data = 0, out_ctrl = 0, out_wr = 0;
  - buf_rd_en = 0, rd_hdr_parser = 0;
  - dst_port = 0, from_flag = 0;
  - counters = 0.
- Outputs are registered. out_data, out_ctrl and out_wr are updated on the clock edge following xfer, giving 1-cycle latency. out_wr = 0 in every cycle with no xfer.
- IDLE→HDRS takes 1 cycle. The first header word can be popped in the cycle after the qualifying IDLE cycle.
- Back-to-back packets: EOP pop in cycle N, IDLE in N+1 (sees the updated parser FIFO), first word of the next packet popped in N+2. Sustained throughput is 1 word/cycle inside a packet.
- out_rdy low: no pop and no out_wr. State and latched dst_port are held indefinitely.
- Reset asserted mid-packet: immediate return to IDLE with all outputs cleared. Buffer and parser contents are not touched by this block; upstream resets them on the same reset.

## Configuration
- Macro OP_LUT_SEQ_STATS_EN.
  - Defined: pkts_from_cpu and pkts_to_cpu ports and counters exist and behave as above.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Single packet from port 2 (is_from_cpu=0, to_cpu_output_port=8'h08): IOQ word 64'h0000_0002_0003_0000 (src port field = 2) → out IOQ field [15:0] = 16'h0008, other bits unchanged. rd_hdr_parser pulses once on EOP. pkts_to_cpu = 1.
- Packet from port 3 (is_from_cpu=1, from_cpu_output_port=8'h04) → dst field = 16'h0004, pkts_from_cpu = 1. 4 data words plus EOP with ctrl=8'h80 forwarded unchanged in order.
- out_rdy held low for 5 cycles mid-payload → no buf_rd_en, no out_wr. Output resumes with the next word; no word is dropped or duplicated.
- Two back-to-back packets with is_from_cpu_vld continuously high → the second header pop occurs exactly 2 cycles after the first EOP pop, and each packet carries its own dst_port.
- Buffer non-empty but is_from_cpu_vld low for 10 cycles → FSM stays IDLE with out_wr = 0. Raising vld starts the packet 1 cycle later.
- Reset pulse during PAYLOAD → out_wr, buf_rd_en and rd_hdr_parser drop to 0 immediately. After release, a fresh packet is sequenced correctly and the counters read 0.
